card_table_server: RTL
======================

Name: card_table_server

Overview:
- Responder side of the display card-table interface.
- Snoops CPU data-memory writes to the card slots (addresses BASE_ADDR..BASE_ADDR+NUM_SLOTS-1) and the win/loss word (WL_ADDR) into a pending bank.
- Commits pending to a display bank at frame boundaries (screenEnd), one entry per cycle, so the VGA controller never shows a half-updated hand.
- Answers the VGA controller's RAMaddr queries with cardIndex, and drives winLoss.

Parameters:
BASE_ADDR, 16, word address of card slot 0
NUM_SLOTS, 10, number of card slots (5 per row, 2 rows)
WL_ADDR, 26, word address of win/loss register
NUM_IMAGES, 14, sprites in the card sheet (valid indices 0..13)
BLANK_INDEX, 13, sprite index used at reset and for out-of-range substitution

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low (0 = reset asserted)
mem_addr  in  32  CPU data-memory word address
mem_data  in  32  CPU write data
mem_wEn  in  1  CPU write strobe, one cycle per write
screenEnd  in  1  one-cycle pulse between frames, from the timing generator
RAMaddr  in  32  display query address (BASE_ADDR + card number)
cardIndex  out  32  registered sprite index for RAMaddr
winLoss  out  2  committed win/loss code: 00 none, 01 win, 10 loss
commit_busy  out  1  high while a commit is in progress
dirty  out  1  pending bank differs from last commit

Behaviour:
- Reset (reset=0, async):
  - pending and display slots = BLANK_INDEX; pending and committed winLoss = 00.
  - cardIndex = 0, commit_busy = 0, dirty = 0, FSM = IDLE, copy index = 0.
- Snoop:
  - If mem_wEn and BASE_ADDR <= mem_addr < BASE_ADDR+NUM_SLOTS: pending[mem_addr-BASE_ADDR] <= mem_data; dirty <= 1.
  - If mem_wEn and mem_addr == WL_ADDR: pending_wl <= mem_data[1:0]; dirty <= 1. The value 11 is stored unchanged.
  - All other addresses are ignored. Writes are accepted every cycle, in any FSM state.
- Commit FSM, two states:
  - IDLE: on screenEnd && dirty -> COPY; idx <= 0; dirty <= 0. A screenEnd with dirty=0 does nothing.
  - COPY: display[idx] <= pending[idx]; idx <= idx+1; commit_busy = 1.
    - At idx == NUM_SLOTS-1, also copy pending_wl to winLoss, then -> IDLE.
    - A commit lasts exactly NUM_SLOTS cycles; winLoss updates at the last one.
    - screenEnd during COPY is ignored.
- Simultaneous events:
  - A write to slot idx in the same cycle it is copied: the new mem_data is forwarded into display[idx].
  - Any accepted write during COPY sets dirty <= 1, even in the copy's final cycle, so the following frame recommits.
  - A write coinciding with the screenEnd that starts COPY: the write wins, dirty stays 1, and the new data is also copied this commit.
- Read port:
  - cardIndex <= display[RAMaddr-BASE_ADDR] when RAMaddr is in range, else 0. Latency 1 cycle.
  - Reads see display only, never pending.
  - Mid-commit reads return the old or new value per slot. This is acceptable because commit starts at screenEnd, outside the active region.
- Width rules: address compare uses the full 32 bits. Slots store 32 bits (4 bits used when the option below is enabled). idx width is $clog2(NUM_SLOTS).
- Reset mid-COPY: immediate return to reset state; the partial commit is discarded.

Optional Feature:
- CARD_RANGE_CHECK_EN defined:
  - A snooped slot write with mem_data >= NUM_IMAGES stores BLANK_INDEX instead.
  - A sticky flag range_err (extra 1-bit output) is set and cleared only by reset.
  - Slots store 4 bits, zero-extended on cardIndex.
- Undefined: mem_data is stored verbatim in 32 bits, and the range_err port is absent.

Test Plan:
- Release reset, query RAMaddr=16..25 -> cardIndex=13 for each slot one cycle later; winLoss=00, dirty=0.
- Write addr 18 data 7, no screenEnd -> dirty=1, RAMaddr=18 still returns 13; pulse screenEnd -> commit_busy high for exactly 10 cycles, then RAMaddr=18 returns 7, dirty=0.
- Write WL_ADDR data 1, screenEnd -> winLoss=01 on the 10th COPY cycle, not earlier; write 2 + screenEnd -> winLoss=10.
- During COPY at idx=3, write addr 17 data 5 and addr 19 data 9 -> after commit, slot 19 shows 9 and slot 17 shows old value; dirty=1; next screenEnd -> slot 17 shows 5.
- Assert reset at COPY idx=4 -> all outputs return to reset values immediately; display slots read 13.
- With CARD_RANGE_CHECK_EN: write addr 20 data 20, commit -> RAMaddr=20 returns 13, range_err=1; RAMaddr=40 returns 0.

Source files
------------

// File: rtl/card_table_server.sv
// card_table_server
// This is the responder side of the display card-table interface.
//
// Pending bank (snoop):
//   - CPU data-memory writes to the card slots (BASE_ADDR .. BASE_ADDR+NUM_SLOTS-1)
//     and to the win/loss word (WL_ADDR) are captured into a pending bank.
//
// Display bank (commit):
//   - At a frame boundary (screenEnd) the pending bank is copied into the
//     display bank, one slot per cycle.
//   - This way the VGA controller never shows a half-updated hand.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous reset, active low
//   mem_addr     CPU data-memory word address
//   mem_data     CPU write data
//   mem_wEn      CPU write strobe
//   screenEnd    one-cycle pulse between frames
//   RAMaddr      display query address (BASE_ADDR + card number)
//   cardIndex    registered sprite index for RAMaddr (0 when out of range)
//   winLoss      committed win/loss code (00 none, 01 win, 10 loss)
//   commit_busy  high while a commit is copying slots
//   dirty        pending bank differs from the last commit
//   range_err    (CARD_RANGE_CHECK_EN only) sticky out-of-range sprite flag
//
// Optional build macro: CARD_RANGE_CHECK_EN
//   - Slots shrink to 4 bits.
//   - Sprite indices >= NUM_IMAGES are replaced by BLANK_INDEX.
//   - The range_err output is added.
//
// Commit FSM
//   state | meaning
//   IDLE  | waiting for screenEnd while dirty
//   COPY  | copying slot copyIdx pending -> display; winLoss on the last slot
module card_table_server #(
    parameter int BASE_ADDR   = 16,
    parameter int NUM_SLOTS   = 10,
    parameter int WL_ADDR     = 26,
    parameter int NUM_IMAGES  = 14,
    parameter int BLANK_INDEX = 13
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_data,
    input  logic        mem_wEn,
    input  logic        screenEnd,
    input  logic [31:0] RAMaddr,
    output logic [31:0] cardIndex,
    output logic [1:0]  winLoss,
    output logic        commit_busy,
    output logic        dirty
`ifdef CARD_RANGE_CHECK_EN
    ,
    output logic        range_err
`endif
);

    localparam int IDX_W = $clog2(NUM_SLOTS);
`ifdef CARD_RANGE_CHECK_EN
    localparam int SLOT_W = 4;
`else
    localparam int SLOT_W = 32;
`endif

    if (BLANK_INDEX >= NUM_IMAGES || NUM_SLOTS < 2) begin : gBadParams
        $error("card_table_server: BLANK_INDEX must be a valid sprite and NUM_SLOTS >= 2");
    end

    typedef enum logic {IDLE, COPY} state_t;

    state_t             state, nextState;
    logic               startCopy;
    logic               lastCopy;
    logic [IDX_W-1:0]   copyIdx;
    logic [SLOT_W-1:0]  pendingSlot [NUM_SLOTS];
    logic [SLOT_W-1:0]  displaySlot [NUM_SLOTS];
    logic [1:0]         pendingWl;
    logic [NUM_SLOTS-1:0] slotHit;
    logic               wlHit;
    logic               anyHit;
    logic [SLOT_W-1:0]  wrVal;
    logic [SLOT_W-1:0]  rdVal;

    // Full 32-bit address compares per slot.
    // Aliased addresses (e.g. upper bits set) never hit a slot.
    always_comb begin
        slotHit = '0;
        rdVal   = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            slotHit[i] = mem_wEn && (mem_addr == 32'(BASE_ADDR + i));
            if (RAMaddr == 32'(BASE_ADDR + i)) begin
                rdVal = displaySlot[i];
            end
        end
    end

    assign wlHit  = mem_wEn && (mem_addr == 32'(WL_ADDR));
    assign anyHit = |slotHit;

`ifdef CARD_RANGE_CHECK_EN
    logic badImage;
    assign badImage = mem_data >= 32'(NUM_IMAGES);
    assign wrVal    = badImage ? SLOT_W'(BLANK_INDEX) : mem_data[SLOT_W-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            range_err <= 1'b0;
        end else if (anyHit && badImage) begin
            range_err <= 1'b1;
        end
    end
`else
    assign wrVal = mem_data;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState   = state;
        commit_busy = 1'b0;
        startCopy   = 1'b0;
        lastCopy    = 1'b0;
        case (state)
            IDLE: begin
                if (screenEnd && dirty) begin
                    startCopy = 1'b1;
                    nextState = COPY;
                end
            end
            COPY: begin
                commit_busy = 1'b1;
                if (copyIdx == IDX_W'(NUM_SLOTS - 1)) begin
                    lastCopy  = 1'b1;
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                pendingSlot[i] <= SLOT_W'(BLANK_INDEX);
                displaySlot[i] <= SLOT_W'(BLANK_INDEX);
            end
            pendingWl <= 2'b00;
            winLoss   <= 2'b00;
            dirty     <= 1'b0;
            copyIdx   <= '0;
            cardIndex <= '0;
        end else begin
            cardIndex <= 32'(rdVal);

            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (slotHit[i]) begin
                    pendingSlot[i] <= wrVal;
                end
            end
            if (wlHit) begin
                pendingWl <= mem_data[1:0];
            end

            // A write always wins over the clear at commit start, so data that
            // lands after a slot was copied still gets committed next frame.
            if (anyHit || wlHit) begin
                dirty <= 1'b1;
            end else if (startCopy) begin
                dirty <= 1'b0;
            end

            if (startCopy) begin
                copyIdx <= '0;
            end else if (commit_busy) begin
                copyIdx <= lastCopy ? '0 : copyIdx + 1'b1;
            end

            // A write to the slot being copied this cycle is forwarded,
            // since pendingSlot has not yet absorbed it.
            if (commit_busy) begin
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    if (copyIdx == IDX_W'(i)) begin
                        displaySlot[i] <= slotHit[i] ? wrVal : pendingSlot[i];
                    end
                end
            end
            if (lastCopy) begin
                winLoss <= pendingWl;
            end
        end
    end

endmodule
